// File: rtl/mpp_beacon_scheduler.sv
// mpp_beacon_scheduler
//   Periodic burst scheduler for the MPP20Beacon generator. Holds beacon_enable high for
//   BURST cycles out of every PERIOD cycles while run is asserted, decimates BeaconData_in
//   by SAMPLE_DIV during each burst into a small first-word-fall-through FIFO, and hands
//   the words downstream over a valid/ready handshake.
// Ports
//   Clk            in   rising-edge system clock
//   Reset          in   synchronous active-high reset
//   run            in   level request for periodic operation
//   beacon_enable  out  generator enable
//   BeaconData_in  in   generator data word
//   m_data         out  FIFO head word (holds last popped word when empty)
//   m_valid        out  FIFO not empty
//   m_ready        in   consumer ready; pop on m_valid & m_ready
//   frame_cnt      out  frames started since reset (wrapping)
//   overflow       out  sticky: a capture was dropped on a full FIFO
//   busy           out  scheduler not idle
module mpp_beacon_scheduler #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned PERIOD     = 15300,
  parameter int unsigned BURST      = 1282,
  parameter int unsigned SAMPLE_DIV = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              run,
  output logic              beacon_enable,
  input  logic [DATA_W-1:0] BeaconData_in,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [15:0]       frame_cnt,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned PC_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned SC_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, GUARD} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [15:0]       frame_q, frame_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              capture;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d, rd_nxt;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              pop, full, push_ok;

  // Frame sequencing: run is only consulted in IDLE and at the last guard cycle
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sc_d    = sc_q;
    frame_d = frame_q;
    en_d    = 1'b0;
    busy_d  = 1'b1;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (run) begin
          state_d = ACTIVE;
          pc_d    = '0;
          sc_d    = '0;
          frame_d = frame_q + 16'd1;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ACTIVE: begin
        pc_d    = pc_q + 1'b1;
        capture = (sc_q == SC_W'(SAMPLE_DIV - 1));
        sc_d    = capture ? '0 : sc_q + 1'b1;
        if (pc_q == PC_W'(BURST - 1)) begin
          state_d = GUARD;
        end else begin
          en_d = 1'b1;
        end
      end
      GUARD: begin
        if (pc_q == PC_W'(PERIOD - 1)) begin
          pc_d = '0;
          sc_d = '0;
          if (run) begin
            state_d = ACTIVE;
            frame_d = frame_q + 16'd1;
            en_d    = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FIFO control; a push into a full FIFO survives only if a pop frees a slot that cycle
  always_comb begin
    pop     = valid_q & m_ready;
    full    = (cnt_q == CW'(FIFO_DEPTH));
    push_ok = capture & (~full | pop);
    ovf_d   = ovf_q | (capture & full & ~pop);
    rd_nxt  = (rd_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
    rd_d    = pop ? rd_nxt : rd_q;
    wr_d    = wr_q;
    if (push_ok) begin
      wr_d = (wr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);
    valid_d = (cnt_d != '0);
    // Registered head: refetch after a pop, bypass the pushed word into an empty FIFO
    data_d  = data_q;
    if (pop) begin
      if (cnt_q > CW'(1)) begin
        data_d = mem_q[rd_nxt];
      end else if (push_ok) begin
        data_d = BeaconData_in;
      end
    end else if ((cnt_q == '0) && push_ok) begin
      data_d = BeaconData_in;
    end
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      sc_q    <= '0;
      frame_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sc_q    <= sc_d;
      frame_q <= frame_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge Clk) begin
    if (push_ok && !Reset) begin
      mem_q[wr_q] <= BeaconData_in;
    end
  end

  assign beacon_enable = en_q;
  assign busy          = busy_q;
  assign frame_cnt     = frame_q;
  assign m_data        = data_q;
  assign m_valid       = valid_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_mpp_beacon_scheduler.sv
// Directed bench for mpp_beacon_scheduler at default parameters.
// BeaconData_in carries the edge count, so every captured word identifies its cycle.
module tb_mpp_beacon_scheduler;

  logic        Clk;
  logic        Reset;
  logic        run;
  logic        beacon_enable;
  logic [23:0] BeaconData_in;
  logic [23:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] frame_cnt;
  logic        overflow;
  logic        busy;

  mpp_beacon_scheduler dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .run           (run),
    .beacon_enable (beacon_enable),
    .BeaconData_in (BeaconData_in),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .frame_cnt     (frame_cnt),
    .overflow      (overflow),
    .busy          (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          cyc;
  int          passed;
  int          total;
  int          en_hi;
  int          en_lo;
  int          last_rise;
  logic        prev_en;
  logic [23:0] popq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: note any handshake completing at this edge, then sample outputs #1 later
  task automatic tick();
    logic        fire;
    logic [23:0] fd;
    fire = m_valid & m_ready;
    fd   = m_data;
    @(posedge Clk);
    #1;
    cyc++;
    if (fire) popq.push_back(fd);
    if (beacon_enable === 1'b1) begin
      en_hi++;
      if (prev_en !== 1'b1) last_rise = cyc;
    end else begin
      en_lo++;
    end
    prev_en       = beacon_enable;
    BeaconData_in = 24'(cyc);
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  int k, f2, f3, f4, f5, bad;

  initial begin
    cyc = 0; passed = 0; total = 0; en_hi = 0; en_lo = 0; last_rise = -1; prev_en = 1'b0;
    Reset = 1'b1; run = 1'b0; m_ready = 1'b1; BeaconData_in = '0;
    repeat (3) tick();
    chk("rst_enable",   32'(beacon_enable), 32'd0);
    chk("rst_valid",    32'(m_valid),       32'd0);
    chk("rst_data",     32'(m_data),        32'd0);
    chk("rst_frame",    32'(frame_cnt),     32'd0);
    chk("rst_overflow", 32'(overflow),      32'd0);
    chk("rst_busy",     32'(busy),          32'd0);

    // Frame 1: enable duty cycle and decimated capture stream
    Reset = 1'b0; run = 1'b1; en_hi = 0; en_lo = 0;
    k = cyc + 1;
    tick();
    chk("f1_enable", 32'(beacon_enable), 32'd1);
    chk("f1_busy",   32'(busy),          32'd1);
    chk("f1_frame",  32'(frame_cnt),     32'd1);
    tick_to(k + 1281);
    chk("f1_last_high", 32'(beacon_enable), 32'd1);
    tick();
    chk("f1_first_low", 32'(beacon_enable), 32'd0);
    tick_to(k + 15299);
    chk("f1_high_cycles", 32'(en_hi), 32'd1282);
    chk("f1_low_cycles",  32'(en_lo), 32'd14018);
    chk("f1_words",       32'(popq.size()), 32'd160);
    chk("f1_first_word",  32'(popq[0]), 32'(k + 7));
    chk("f1_last_word",   32'(popq[159]), 32'(k + 1279));
    bad = 0;
    for (int i = 1; i < popq.size(); i++) if (popq[i] - popq[i-1] != 24'd8) bad++;
    chk("f1_step8", 32'(bad), 32'd0);
    chk("f1_drained", 32'(m_valid), 32'd0);

    // Frame 2: stall consumer, fill FIFO, pop+push on full, then overflow
    m_ready = 1'b0; popq.delete();
    f2 = k + 15300;
    tick();
    chk("f2_rise_gap", 32'(last_rise - k), 32'd15300);
    chk("f2_frame",    32'(frame_cnt),     32'd2);
    tick_to(f2 + 33);
    chk("full_valid",  32'(m_valid),  32'd1);
    chk("full_head",   32'(m_data),   32'(f2 + 7));
    chk("full_no_ovf", 32'(overflow), 32'd0);
    tick_to(f2 + 39);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("pp_head",     32'(m_data),       32'(f2 + 15));
    chk("pp_no_ovf",   32'(overflow),     32'd0);
    chk("pp_popped_n", 32'(popq.size()),  32'd1);
    chk("pp_popped",   32'(popq[0]),      32'(f2 + 7));
    tick_to(f2 + 47);
    chk("pre_ovf", 32'(overflow), 32'd0);
    tick();
    chk("ovf_set",  32'(overflow), 32'd1);
    chk("ovf_head", 32'(m_data),   32'(f2 + 15));
    tick_to(f2 + 1400);
    chk("stall_head",   32'(m_data),        32'(f2 + 15));
    chk("stall_ovf",    32'(overflow),      32'd1);
    chk("stall_enable", 32'(beacon_enable), 32'd0);
    popq.delete(); m_ready = 1'b1;
    repeat (6) tick();
    chk("drain_n",     32'(popq.size()), 32'd4);
    chk("drain_0",     32'(popq[0]),     32'(f2 + 15));
    chk("drain_1",     32'(popq[1]),     32'(f2 + 23));
    chk("drain_2",     32'(popq[2]),     32'(f2 + 31));
    chk("drain_3",     32'(popq[3]),     32'(f2 + 39));
    chk("drain_empty", 32'(m_valid),     32'd0);
    chk("drain_hold",  32'(m_data),      32'(f2 + 39));

    // Frame 3: drop run mid-burst; frame completes, then scheduler idles
    f3 = k + 30600;
    tick_to(f3 + 600);
    chk("f3_rise_gap", 32'(last_rise - f2), 32'd15300);
    chk("f3_frame",    32'(frame_cnt),      32'd3);
    run = 1'b0;
    tick_to(f3 + 1281);
    chk("f3_last_high", 32'(beacon_enable), 32'd1);
    tick();
    chk("f3_first_low", 32'(beacon_enable), 32'd0);
    tick_to(f3 + 15299);
    chk("f3_guard_busy", 32'(busy), 32'd1);
    tick();
    chk("f3_idle_busy", 32'(busy), 32'd0);
    en_hi = 0;
    repeat (200) tick();
    chk("idle_no_enable", 32'(en_hi),     32'd0);
    chk("idle_frame",     32'(frame_cnt), 32'd3);

    // Frame 4: reset mid-burst with words queued, then restart
    m_ready = 1'b0; run = 1'b1;
    f4 = cyc + 1;
    tick();
    chk("f4_enable", 32'(beacon_enable), 32'd1);
    chk("f4_frame",  32'(frame_cnt),     32'd4);
    tick_to(f4 + 500);
    chk("f4_valid", 32'(m_valid),  32'd1);
    chk("f4_ovf",   32'(overflow), 32'd1);
    Reset = 1'b1;
    tick();
    chk("mid_rst_enable", 32'(beacon_enable), 32'd0);
    chk("mid_rst_valid",  32'(m_valid),       32'd0);
    chk("mid_rst_frame",  32'(frame_cnt),     32'd0);
    chk("mid_rst_ovf",    32'(overflow),      32'd0);
    chk("mid_rst_busy",   32'(busy),          32'd0);
    chk("mid_rst_data",   32'(m_data),        32'd0);
    Reset = 1'b0;
    tick();
    chk("restart_enable", 32'(beacon_enable), 32'd1);
    chk("restart_frame",  32'(frame_cnt),     32'd1);
    chk("restart_busy",   32'(busy),          32'd1);
    f5 = cyc;
    tick_to(f5 + 7);
    chk("restart_empty", 32'(m_valid), 32'd0);
    tick();
    chk("restart_valid", 32'(m_valid), 32'd1);
    chk("restart_word",  32'(m_data),  32'(f5 + 7));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
